// File: rtl/sram_act_reader.sv
// sram_act_reader
//   Reads a space-to-depth activation tensor out of SRAM group A or group B.
//   Each group has four banks. The reader streams the tensor back as single
//   activations in raster order: channel outer, row middle, column inner.
//   The output uses a ready/valid handshake.
//
//   Each SRAM word holds one 2x2 spatial block for every channel. The block
//   at (by, bx) is stored in bank {by[0], bx[0]} at address
//   (by>>1)*ROW_STRIDE + (bx>>1). Activation index c*ACT_PER_ADDR+k is
//   packed MSB-first.
//
//   Build option READER_ZERO_PAD_EN: when defined, each channel is emitted
//   as a (FMAP_DIM+2)^2 map with a one-pixel zero border. Border elements
//   skip the SRAM read but still use a pipeline slot and a FIFO credit.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, sel_b        start a readback (IDLE only); group select latched with start
//   sram_rdata_a0..b3   bank read data, valid one cycle after the address
//   sram_raddr_a0..b3   registered bank read addresses
//   out_valid/out_ready output handshake
//   out_data, out_ch, out_row, out_col, out_last
//                       activation, its coordinates, and the end-of-readback flag
//   busy                high from start acceptance until done
//   done                one-cycle pulse after the final transfer
module sram_act_reader #(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 8,
  parameter int FMAP_DIM     = 14,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       sel_b,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a0,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a1,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a2,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_a3,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b0,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b1,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b2,
  input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]  sram_rdata_b3,
  output logic [5:0]                                 sram_raddr_a0,
  output logic [5:0]                                 sram_raddr_a1,
  output logic [5:0]                                 sram_raddr_a2,
  output logic [5:0]                                 sram_raddr_a3,
  output logic [5:0]                                 sram_raddr_b0,
  output logic [5:0]                                 sram_raddr_b1,
  output logic [5:0]                                 sram_raddr_b2,
  output logic [5:0]                                 sram_raddr_b3,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BW_PER_ACT-1:0]                      out_data,
  output logic [$clog2(CH_NUM)-1:0]                  out_ch,
  output logic [4:0]                                 out_row,
  output logic [4:0]                                 out_col,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int WORD_W     = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int ROW_STRIDE = (FMAP_DIM + 3) / 4;
  localparam int NUM_BANKS  = 4;
  localparam int CW         = $clog2(CH_NUM);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
`ifdef READER_ZERO_PAD_EN
  localparam int SPAN = FMAP_DIM + 2;
`else
  localparam int SPAN = FMAP_DIM;
`endif
  localparam logic [4:0]    SPAN_LAST = 5'(SPAN - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(CH_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Metadata that travels with each read through the two-cycle SRAM pipeline.
  typedef struct packed {
    logic          pad;
    logic          last;
    logic [1:0]    bank;
    logic [1:0]    k;
    logic [CW-1:0] c;
    logic [4:0]    row;
    logic [4:0]    col;
  } meta_t;

  logic [WORD_W-1:0] rdata_a [NUM_BANKS];
  logic [WORD_W-1:0] rdata_b [NUM_BANKS];
  logic [5:0]        raddr_a_reg [NUM_BANKS];
  logic [5:0]        raddr_b_reg [NUM_BANKS];

  assign rdata_a[0] = sram_rdata_a0;
  assign rdata_a[1] = sram_rdata_a1;
  assign rdata_a[2] = sram_rdata_a2;
  assign rdata_a[3] = sram_rdata_a3;
  assign rdata_b[0] = sram_rdata_b0;
  assign rdata_b[1] = sram_rdata_b1;
  assign rdata_b[2] = sram_rdata_b2;
  assign rdata_b[3] = sram_rdata_b3;
  assign sram_raddr_a0 = raddr_a_reg[0];
  assign sram_raddr_a1 = raddr_a_reg[1];
  assign sram_raddr_a2 = raddr_a_reg[2];
  assign sram_raddr_a3 = raddr_a_reg[3];
  assign sram_raddr_b0 = raddr_b_reg[0];
  assign sram_raddr_b1 = raddr_b_reg[1];
  assign sram_raddr_b2 = raddr_b_reg[2];
  assign sram_raddr_b3 = raddr_b_reg[3];

  state_t            state_reg;
  logic              sel_b_reg;
  logic [CW-1:0]     c_reg;
  logic [4:0]        row_reg;
  logic [4:0]        col_reg;
  logic              s0_v_reg, s1_v_reg;
  meta_t             s0_reg, s1_reg;
  logic              busy_reg, done_reg;

  // Small output FIFO. The head entry drives the outputs directly, so they
  // stay stable while the consumer stalls.
  logic [BW_PER_ACT-1:0] fifo_data_reg [FIFO_DEPTH];
  logic [CW-1:0]         fifo_ch_reg   [FIFO_DEPTH];
  logic [4:0]            fifo_row_reg  [FIFO_DEPTH];
  logic [4:0]            fifo_col_reg  [FIFO_DEPTH];
  logic                  fifo_last_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue side: map the current output coordinate to its bank, address and lane.
  logic [4:0] src_r, src_x;
  logic       iss_pad;
  logic [5:0] iss_addr;
  meta_t      iss_meta;
  logic       can_issue;

  always_comb begin
`ifdef READER_ZERO_PAD_EN
    iss_pad = (row_reg == 5'd0) || (row_reg == SPAN_LAST) ||
              (col_reg == 5'd0) || (col_reg == SPAN_LAST);
    src_r   = row_reg - 5'd1;
    src_x   = col_reg - 5'd1;
`else
    iss_pad = 1'b0;
    src_r   = row_reg;
    src_x   = col_reg;
`endif
    iss_addr      = 6'(int'(src_r[4:2]) * ROW_STRIDE + int'(src_x[4:2]));
    iss_meta.pad  = iss_pad;
    iss_meta.last = (c_reg == CH_LAST) && (row_reg == SPAN_LAST) && (col_reg == SPAN_LAST);
    iss_meta.bank = {src_r[1], src_x[1]};
    iss_meta.k    = {src_r[0], src_x[0]};
    iss_meta.c    = c_reg;
    iss_meta.row  = row_reg;
    iss_meta.col  = col_reg;
    // Credit check: every read in flight already owns a FIFO slot, so a
    // capture can never find the FIFO full.
    can_issue = (state_reg == RUN) &&
                (int'(count_reg) + int'(s0_v_reg) + int'(s1_v_reg) < FIFO_DEPTH);
  end

  // Capture side: pick the lane out of the word returned for stage-1 metadata.
  logic [WORD_W-1:0]     cap_word;
  logic [BW_PER_ACT-1:0] cap_data;
  logic                  push, pop;

  always_comb begin
    cap_word = sel_b_reg ? rdata_b[s1_reg.bank] : rdata_a[s1_reg.bank];
    cap_data = cap_word[BW_PER_ACT * (CH_NUM * ACT_PER_ADDR - 1 -
               (int'(s1_reg.c) * ACT_PER_ADDR + int'(s1_reg.k))) +: BW_PER_ACT];
    if (s1_reg.pad) cap_data = '0;
  end

  assign out_valid = (count_reg != '0);
  assign push      = s1_v_reg;
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data_reg[rd_ptr_reg];
  assign out_ch    = fifo_ch_reg[rd_ptr_reg];
  assign out_row   = fifo_row_reg[rd_ptr_reg];
  assign out_col   = fifo_col_reg[rd_ptr_reg];
  assign out_last  = fifo_last_reg[rd_ptr_reg];
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_b_reg  <= 1'b0;
      c_reg      <= '0;
      row_reg    <= '0;
      col_reg    <= '0;
      s0_v_reg   <= 1'b0;
      s1_v_reg   <= 1'b0;
      s0_reg     <= '0;
      s1_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        raddr_a_reg[b] <= '0;
        raddr_b_reg[b] <= '0;
      end
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        fifo_data_reg[e] <= '0;
        fifo_ch_reg[e]   <= '0;
        fifo_row_reg[e]  <= '0;
        fifo_col_reg[e]  <= '0;
        fifo_last_reg[e] <= 1'b0;
      end
    end else begin
      done_reg <= 1'b0;

      // Two-stage read pipeline: the address is registered at issue and the
      // data is returned by the SRAM one cycle later.
      s0_v_reg <= can_issue;
      s0_reg   <= iss_meta;
      s1_v_reg <= s0_v_reg;
      s1_reg   <= s0_reg;

      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= cap_data;
        fifo_ch_reg[wr_ptr_reg]   <= s1_reg.c;
        fifo_row_reg[wr_ptr_reg]  <= s1_reg.row;
        fifo_col_reg[wr_ptr_reg]  <= s1_reg.col;
        fifo_last_reg[wr_ptr_reg] <= s1_reg.last;
        wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            sel_b_reg <= sel_b;
            busy_reg  <= 1'b1;
            c_reg     <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            // Start from clean addresses, so the unselected group reads 0 throughout.
            for (int b = 0; b < NUM_BANKS; b++) begin
              raddr_a_reg[b] <= '0;
              raddr_b_reg[b] <= '0;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            if (!iss_pad) begin
              if (sel_b_reg) raddr_b_reg[iss_meta.bank] <= iss_addr;
              else           raddr_a_reg[iss_meta.bank] <= iss_addr;
            end
            if (col_reg == SPAN_LAST) begin
              col_reg <= '0;
              if (row_reg == SPAN_LAST) begin
                row_reg <= '0;
                c_reg   <= c_reg + 1'b1;
              end else begin
                row_reg <= row_reg + 5'd1;
              end
            end else begin
              col_reg <= col_reg + 5'd1;
            end
            if (iss_meta.last) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // The last element leaves the FIFO behind every other element, so
          // its transfer means the pipeline and FIFO are empty.
          if (pop && out_last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_act_reader.sv
module tb_sram_act_reader;
  localparam int CH_NUM = 4;
  localparam int APA    = 4;
  localparam int BW     = 8;
  localparam int DIM    = 14;
  localparam int WORD_W = CH_NUM * APA * BW;
  localparam int ROW_STRIDE = (DIM + 3) / 4;
`ifdef READER_ZERO_PAD_EN
  localparam bit PAD  = 1'b1;
  localparam int SPAN = DIM + 2;
`else
  localparam bit PAD  = 1'b0;
  localparam int SPAN = DIM;
`endif
  localparam int TOTAL = CH_NUM * SPAN * SPAN;

  logic clk, rst_n, start, sel_b, out_ready;
  logic [WORD_W-1:0] rd_a [4];
  logic [WORD_W-1:0] rd_b [4];
  logic [5:0] raddr_a0, raddr_a1, raddr_a2, raddr_a3;
  logic [5:0] raddr_b0, raddr_b1, raddr_b2, raddr_b3;
  logic out_valid, out_last, busy, done;
  logic [BW-1:0] out_data;
  logic [1:0] out_ch;
  logic [4:0] out_row, out_col;

  logic [WORD_W-1:0] mem_a [4][64];
  logic [WORD_W-1:0] mem_b [4][64];

  sram_act_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_b(sel_b),
    .sram_rdata_a0(rd_a[0]), .sram_rdata_a1(rd_a[1]),
    .sram_rdata_a2(rd_a[2]), .sram_rdata_a3(rd_a[3]),
    .sram_rdata_b0(rd_b[0]), .sram_rdata_b1(rd_b[1]),
    .sram_rdata_b2(rd_b[2]), .sram_rdata_b3(rd_b[3]),
    .sram_raddr_a0(raddr_a0), .sram_raddr_a1(raddr_a1),
    .sram_raddr_a2(raddr_a2), .sram_raddr_a3(raddr_a3),
    .sram_raddr_b0(raddr_b0), .sram_raddr_b1(raddr_b1),
    .sram_raddr_b2(raddr_b2), .sram_raddr_b3(raddr_b3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM banks.
  always @(posedge clk) begin
    rd_a[0] <= mem_a[0][raddr_a0];
    rd_a[1] <= mem_a[1][raddr_a1];
    rd_a[2] <= mem_a[2][raddr_a2];
    rd_a[3] <= mem_a[3][raddr_a3];
    rd_b[0] <= mem_b[0][raddr_b0];
    rd_b[1] <= mem_b[1][raddr_b1];
    rd_b[2] <= mem_b[2][raddr_b2];
    rd_b[3] <= mem_b[3][raddr_b3];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard entry: {ch, row, col, last} above the 8 data bits.
  int sb[$];
  int xfer_cnt, last_cyc, done_cnt, done_cyc, cyc;
  bit bad_addr, sel_grp, rand_ready, stalled;
  int held_word;

  function automatic int pack_elem(int data, int c, int row, int col, bit last);
    return (((c << 11) | (row << 6) | (col << 1) | int'(last)) << 8) | (data & 255);
  endfunction

  function automatic int cur_word();
    return pack_elem(int'(out_data), int'(out_ch), int'(out_row), int'(out_col), out_last);
  endfunction

  // Store activation(c,r,x) = 16*c + r + x, or fill the group with junk.
  task automatic load_group(input bit grp, input bit junk);
    logic [WORD_W-1:0] word;
    int bank, addr, i;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++) begin
        word = junk ? {16{8'hEE}} : '0;
        if (grp) mem_b[b][a] = word; else mem_a[b][a] = word;
      end
    if (!junk)
      for (int c = 0; c < CH_NUM; c++)
        for (int r = 0; r < DIM; r++)
          for (int x = 0; x < DIM; x++) begin
            bank = 2 * ((r >> 1) & 1) + ((x >> 1) & 1);
            addr = (r >> 2) * ROW_STRIDE + (x >> 2);
            i    = c * APA + 2 * (r & 1) + (x & 1);
            if (grp) mem_b[bank][addr][BW*(CH_NUM*APA-1-i) +: BW] = 8'(16 * c + r + x);
            else     mem_a[bank][addr][BW*(CH_NUM*APA-1-i) +: BW] = 8'(16 * c + r + x);
          end
  endtask

  task automatic push_expected();
    int val;
    bit border;
    for (int c = 0; c < CH_NUM; c++)
      for (int r = 0; r < SPAN; r++)
        for (int x = 0; x < SPAN; x++) begin
          border = PAD && (r == 0 || x == 0 || r == SPAN - 1 || x == SPAN - 1);
          if (border)   val = 0;
          else if (PAD) val = 16 * c + (r - 1) + (x - 1);
          else          val = 16 * c + r + x;
          sb.push_back(pack_elem(val, c, r, x,
                       (c == CH_NUM - 1) && (r == SPAN - 1) && (x == SPAN - 1)));
        end
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_valid"}, int'(out_valid), 0);
    check({pfx, "_word"}, cur_word(), 0);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_done"}, int'(done), 0);
    check({pfx, "_raddr"}, int'(|{raddr_a0, raddr_a1, raddr_a2, raddr_a3,
                                   raddr_b0, raddr_b1, raddr_b2, raddr_b3}), 0);
  endtask

  // Consumer-side ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pop and compare on each transfer, check hold while stalled.
  initial begin
    cyc = 0;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_word", cur_word(), held_word);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("extra_xfer", 1, 0);
          end else begin
            int exp_elem;
            exp_elem = sb.pop_front();
            check("data", int'(out_data), exp_elem & 255);
            check("coord", cur_word() >> 8, exp_elem >> 8);
          end
          xfer_cnt++;
          last_cyc = cyc;
        end
        stalled   = out_valid && !out_ready;
        held_word = cur_word();
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy)
          bad_addr |= sel_grp ? (|{raddr_a0, raddr_a1, raddr_a2, raddr_a3})
                              : (|{raddr_b0, raddr_b1, raddr_b2, raddr_b3});
      end
    end
  end

  task automatic run_stream(input bit grp, input bit rnd, input int restart_at, input int rst_at);
    int lat, tail;
    bit finished, restarted;
    sb.delete();
    push_expected();
    sel_grp = grp; rand_ready = rnd;
    xfer_cnt = 0; done_cnt = 0; bad_addr = 1'b0;
    last_cyc = -100; done_cyc = 0;
    finished = 1'b0; restarted = 1'b0; tail = -1;
    @(posedge clk); #1;
    start = 1'b1; sel_b = grp;
    @(posedge clk); #1;                  // start accepted on this edge
    start = 1'b0; sel_b = ~grp;          // mid-run select change must be ignored
    check("busy_on", int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    for (int n = 0; n < 30000 && !finished; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_at >= 0 && !restarted && xfer_cnt >= restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (rst_at >= 0 && xfer_cnt >= rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle("midrst");
        sb.delete();
        $display("readback grp=%0d aborted by reset after %0d transfers", grp, xfer_cnt);
        return;
      end
      if (done_cnt > 0) begin
        if (tail < 0) tail = 3;
        else begin
          tail--;
          if (tail == 0) finished = 1'b1;
        end
      end
    end
    if (!finished) check("timeout", 0, 1);
    check("xfers", xfer_cnt, TOTAL);
    check("sb_left", sb.size(), 0);
    check("done_cnt", done_cnt, 1);
    check("done_lag", done_cyc - last_cyc, 1);
    check("busy_off", int'(busy), 0);
    check("other_grp_raddr", int'(bad_addr), 0);
    $display("readback grp=%0d rnd_ready=%0d restart_at=%0d: %0d transfers",
             grp, rnd, restart_at, xfer_cnt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel_b = 1'b0; rand_ready = 1'b0;
    load_group(1'b0, 1'b0);
    load_group(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    run_stream(1'b0, 1'b0, -1, -1);      // group A, ready held high
    load_group(1'b0, 1'b1);
    load_group(1'b1, 1'b0);
    run_stream(1'b1, 1'b0, -1, -1);      // group B, same stream expected
    load_group(1'b0, 1'b0);
    run_stream(1'b0, 1'b1, -1, -1);      // random backpressure
    run_stream(1'b0, 1'b0, 100, -1);     // start while busy is ignored
    run_stream(1'b0, 1'b1, -1, 300);     // reset mid-run
    run_stream(1'b0, 1'b0, -1, -1);      // clean run after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
